// File: rtl/seg_scan_mux.sv
// rtl/seg_scan_mux.sv - time-multiplexed scan driver for N common-cathode 7-segment digits
//
// Scans NUM_DIGITS digits, one slot of SCAN_DIV clocks each, with BLANK_CYC
// blanked clocks at the start of every slot to suppress ghosting.
// Optional feature macro: SEG_SCAN_BRIGHTNESS_PWM_EN (per-cycle PWM dimming).
//
// Ports:
//   clk          system clock
//   rst_n        asynchronous active-low reset
//   digits_in    7*NUM_DIGITS segment patterns, digit k = [7k+6:7k], 1 = lit
//   digit_en     per-digit enable, 0 keeps that digit dark
//   brightness   PWM duty (used only with SEG_SCAN_BRIGHTNESS_PWM_EN)
//   segment      registered segment drive (inverted when SEG_ACTIVE_LOW)
//   anode_ctrl   registered digit select, active-low, one-cold
//   frame_start  one-cycle pulse at the start of the digit-0 slot
module seg_scan_mux #(
    parameter int NUM_DIGITS     = 8,
    parameter int SCAN_DIV       = 1000,
    parameter int BLANK_CYC      = 2,
    parameter int SEG_ACTIVE_LOW = 0
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [7*NUM_DIGITS-1:0] digits_in,
    input  logic [NUM_DIGITS-1:0]   digit_en,
    input  logic [3:0]              brightness,
    output logic [6:0]              segment,
    output logic [NUM_DIGITS-1:0]   anode_ctrl,
    output logic                    frame_start
);

    localparam int CW = $clog2(SCAN_DIV);
    localparam int IW = (NUM_DIGITS > 2) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(SCAN_DIV - 1);
    localparam logic [IW-1:0] IDX_LAST = IW'(NUM_DIGITS - 1);
    // Off pattern doubles as the XOR mask for active-low segment wiring.
    localparam logic [6:0]    SEG_OFF  = (SEG_ACTIVE_LOW != 0) ? 7'h7F : 7'h00;

    logic [CW-1:0] cnt;
    logic [IW-1:0] idx;
    logic [6:0]    hold;
    logic          hold_en;

    logic [6:0]    pat_arr [NUM_DIGITS];
    logic          slot_start;
    logic          in_blank;
    logic [6:0]    cur_pat;
    logic          cur_en;
    logic          lit;

    for (genvar k = 0; k < NUM_DIGITS; k++) begin : g_slice
        assign pat_arr[k] = digits_in[7*k +: 7];
    end

    if (BLANK_CYC == 0) begin : g_noblank
        assign in_blank = 1'b0;
    end else begin : g_blank
        assign in_blank = (32'(cnt) < BLANK_CYC);
    end

    assign slot_start = (cnt == '0);

    // At slot start the live inputs are used so the first visible cycle
    // already reflects them; afterwards the captured copy prevents tearing.
    assign cur_pat = slot_start ? pat_arr[idx]  : hold;
    assign cur_en  = slot_start ? digit_en[idx] : hold_en;

`ifdef SEG_SCAN_BRIGHTNESS_PWM_EN
    logic [3:0] pwm_cnt;
    logic [3:0] hold_bright;
    logic [3:0] cur_bright;
    logic       pwm_on;

    assign cur_bright = slot_start ? brightness : hold_bright;
    assign pwm_on     = (cur_bright == 4'hF) || (pwm_cnt < cur_bright);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pwm_cnt     <= '0;
            hold_bright <= '0;
        end else begin
            pwm_cnt <= pwm_cnt + 4'd1;
            if (slot_start) begin
                hold_bright <= brightness;
            end
        end
    end
`else
    logic unused_brightness;
    logic pwm_on;

    assign unused_brightness = ^brightness;
    assign pwm_on            = 1'b1;
`endif

    // A disabled digit still consumes its slot so frame timing stays uniform.
    assign lit = !in_blank && cur_en && pwm_on;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt         <= '0;
            idx         <= '0;
            hold        <= '0;
            hold_en     <= 1'b0;
            segment     <= SEG_OFF;
            anode_ctrl  <= '1;
            frame_start <= 1'b0;
        end else begin
            if (cnt == CNT_LAST) begin
                cnt <= '0;
                idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
            end else begin
                cnt <= cnt + 1'b1;
            end
            if (slot_start) begin
                hold    <= cur_pat;
                hold_en <= cur_en;
            end
            segment     <= lit ? (cur_pat ^ SEG_OFF) : SEG_OFF;
            anode_ctrl  <= lit ? ~(NUM_DIGITS'(1) << idx) : '1;
            frame_start <= slot_start && (idx == '0);
        end
    end

endmodule

// File: tb/tb_seg_scan_mux.sv
// tb/tb_seg_scan_mux.sv - self-checking bench for seg_scan_mux
module tb_seg_scan_mux;

    localparam int ND = 4;
    localparam int SD = 4;
    localparam int BL = 1;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [6:0]    dig [ND];
    logic [27:0]   digits_in;
    logic [3:0]    digit_en = 4'hF;
    logic [3:0]    brightness = 4'hF;
    logic [6:0]    segment, segment_al;
    logic [3:0]    anode_ctrl, anode_al;
    logic          frame_start, frame_start_al;

    always #5 clk = ~clk;

    always_comb digits_in = {dig[3], dig[2], dig[1], dig[0]};

    seg_scan_mux #(.NUM_DIGITS(ND), .SCAN_DIV(SD), .BLANK_CYC(BL), .SEG_ACTIVE_LOW(0)) dut (
        .clk(clk), .rst_n(rst_n), .digits_in(digits_in), .digit_en(digit_en),
        .brightness(brightness), .segment(segment), .anode_ctrl(anode_ctrl),
        .frame_start(frame_start));

    seg_scan_mux #(.NUM_DIGITS(ND), .SCAN_DIV(SD), .BLANK_CYC(BL), .SEG_ACTIVE_LOW(1)) dut_al (
        .clk(clk), .rst_n(rst_n), .digits_in(digits_in), .digit_en(digit_en),
        .brightness(brightness), .segment(segment_al), .anode_ctrl(anode_al),
        .frame_start(frame_start_al));

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: edges counted since reset release; slot, digit and
    // pwm phase follow arithmetically from that count.
    int         n = 0;
    logic [6:0] cap_pat = '0;
    logic       cap_en = 1'b0;
    logic [3:0] cap_b = '0;
    logic [3:0] exp_an;
    logic [6:0] exp_seg;
    logic       exp_fs;

    task automatic tick();
        int   c, i;
        logic vis;
        @(posedge clk);
        c = n % SD;
        i = (n / SD) % ND;
        if (c == 0) begin
            cap_pat = dig[i];
            cap_en  = digit_en[i];
            cap_b   = brightness;
        end
        vis = (c >= BL) && cap_en;
`ifdef SEG_SCAN_BRIGHTNESS_PWM_EN
        vis = vis && ((cap_b == 4'hF) || ((n % 16) < int'(cap_b)));
`endif
        exp_an  = vis ? ~(4'b0001 << i) : 4'hF;
        exp_seg = vis ? cap_pat : 7'h00;
        exp_fs  = (c == 0) && (i == 0);
        n++;
        @(negedge clk);
        check("anode", 32'(anode_ctrl), 32'(exp_an));
        check("segment", 32'(segment), 32'(exp_seg));
        check("frame_start", 32'(frame_start), 32'(exp_fs));
        check("anode_al", 32'(anode_al), 32'(exp_an));
        check("segment_al", 32'(segment_al), 32'(exp_seg ^ 7'h7F));
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("rst_anode", 32'(anode_ctrl), 32'hF);
        check("rst_segment", 32'(segment), 32'h00);
        check("rst_segment_al", 32'(segment_al), 32'h7F);
        check("rst_frame_start", 32'(frame_start), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        n = 0;
    endtask

    typedef struct {
        logic [3:0] en;
        logic [3:0] anode;
        logic [6:0] seg;
        logic       fs;
    } vec_t;

    vec_t vt [33];

    task automatic fill(input int base, input logic [3:0] en, input logic [3:0] an,
                        input logic [6:0] seg, input logic fs);
        vt[base] = '{en, 4'hF, 7'h00, fs};
        for (int j = 1; j < 4; j++) vt[base + j] = '{en, an, seg, 1'b0};
    endtask

    task automatic run_table(input int first, input int last);
        for (int k = first; k <= last; k++) begin
            digit_en = vt[k].en;
            @(posedge clk);
            @(negedge clk);
            check($sformatf("tbl%0d_anode", k), 32'(anode_ctrl), 32'(vt[k].anode));
            check($sformatf("tbl%0d_segment", k), 32'(segment), 32'(vt[k].seg));
            check($sformatf("tbl%0d_fs", k), 32'(frame_start), 32'(vt[k].fs));
            check($sformatf("tbl%0d_seg_al", k), 32'(segment_al), 32'(vt[k].seg ^ 7'h7F));
        end
    endtask

    task automatic default_digits();
        dig[0] = 7'h66; dig[1] = 7'h4F; dig[2] = 7'h5B; dig[3] = 7'h06;
    endtask

    initial begin
        default_digits();
        fill(0,  4'hF, 4'b1110, 7'h66, 1'b1);
        fill(4,  4'hF, 4'b1101, 7'h4F, 1'b0);
        fill(8,  4'hF, 4'b1011, 7'h5B, 1'b0);
        fill(12, 4'hF, 4'b0111, 7'h06, 1'b0);
        fill(16, 4'hA, 4'b1111, 7'h00, 1'b1);
        fill(20, 4'hA, 4'b1101, 7'h4F, 1'b0);
        fill(24, 4'hA, 4'b1111, 7'h00, 1'b0);
        fill(28, 4'hA, 4'b0111, 7'h06, 1'b0);
        vt[32] = '{4'hA, 4'hF, 7'h00, 1'b1};

        // Full-enable frame, then sparse-enable frame plus next frame start.
        digit_en = 4'hF;
        do_reset();
        run_table(0, 15);
        digit_en = 4'hA;
        do_reset();
        run_table(16, 32);

        // Mid-slot input change must not tear the displayed digit.
        digit_en = 4'hF;
        do_reset();
        tick(); tick();
        dig[0] = 7'h3F;
        tick();
        check("tear_cnt2", 32'(segment), 32'h66);
        tick();
        check("tear_cnt3", 32'(segment), 32'h66);
        while (n < 18) tick();
        check("tear_next_frame", 32'(segment), 32'h3F);

        // Reset in the middle of slot 2: blank at once, restart at digit 0.
        default_digits();
        do_reset();
        while (n < 10) tick();
        check("pre_reset_lit", 32'(anode_ctrl), 32'hB);
        rst_n = 1'b0;
        #1;
        check("async_anode", 32'(anode_ctrl), 32'hF);
        check("async_segment", 32'(segment), 32'h00);
        @(negedge clk);
        rst_n = 1'b1;
        n = 0;
        tick(); tick();
        check("restart_digit0", 32'(anode_ctrl), 32'hE);

        // Active-low segment polarity with pattern 7'h06.
        dig[0] = 7'h06;
        do_reset();
        tick();
        check("al_blank", 32'(segment_al), 32'h7F);
        tick();
        check("al_lit", 32'(segment_al), 32'h79);

        // Randomized inputs against the model.
        default_digits();
        do_reset();
        for (int r = 0; r < 600; r++) begin
            if ($urandom_range(0, 3) == 0) dig[$urandom_range(0, ND - 1)] = 7'($urandom);
            if ($urandom_range(0, 7) == 0) digit_en = 4'($urandom);
            if ($urandom_range(0, 15) == 0) brightness = 4'($urandom);
            tick();
        end

`ifdef SEG_SCAN_BRIGHTNESS_PWM_EN
        // Fixed brightness levels over whole frames.
        foreach (vt[b]) begin end
        for (int b = 0; b < 3; b++) begin
            brightness = (b == 0) ? 4'd0 : (b == 1) ? 4'd4 : 4'hF;
            digit_en = 4'hF;
            do_reset();
            for (int r = 0; r < 64; r++) tick();
        end
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
